inverse_comb_filter: RTL and testbench



---
 rtl/inverse_comb_filter.sv | 187 ++++++++++++++++++
 tb/tb_inverse_comb_filter.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/inverse_comb_filter.sv
// -----------------------------------------------------------------------------
// inverse_comb_filter
//
// Feedforward comb that cancels a single recirculating echo:
//     y[n] = x[n] - g * x[n-DELAY]
// This is the exact inverse of the feedback comb in the reverb path. The block
// takes one 16-bit sample per din_valid strobe and runs a 4-state FSM
// (IDLE -> READ -> CALC -> OUT) around a single-port delay RAM. The RAM holds
// raw input samples, so the echo term is always built from clean history.
//
// Parameters:
//   DELAY     delay length in samples (>= 2)
//   FEEDBACK  echo gain g, signed Q1.15
//
// Ports:
//   clk         system clock
//   reset       asynchronous, active-low reset
//   din         signed input sample, taken while din_valid is high in IDLE
//   din_valid   one-cycle strobe marking a new sample
//   dout        echo-cancelled sample, held between dout_valid pulses
//   dout_valid  one-cycle strobe, dout updated (3 clocks after the strobe)
//   busy        high while a sample is in flight
//   overrun     sticky; a strobe arrived while busy (cleared only by reset)
// -----------------------------------------------------------------------------
module inverse_comb_filter #(
    parameter int                 DELAY    = 3000,
    parameter logic signed [15:0] FEEDBACK = 16'sd22937
) (
    input  logic               clk,
    input  logic               reset,
    input  logic signed [15:0] din,
    input  logic               din_valid,
    output logic signed [15:0] dout,
    output logic               dout_valid,
    output logic               busy,
    output logic               overrun
);

    localparam int ADDR_WIDTH = $clog2(DELAY);
    // fill must be able to hold DELAY itself, so it may need one more bit
    localparam int FILL_WIDTH = $clog2(DELAY + 1);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DELAY - 1);
    localparam logic [FILL_WIDTH-1:0] FILL_FULL = FILL_WIDTH'(DELAY);
    localparam logic signed [31:0]    FB_EXT    = 32'(FEEDBACK);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        CALC = 2'd2,
        OUT  = 2'd3
    } state_t;

    // Clamp a wide signed difference into the 16-bit output range.
    function automatic logic signed [15:0] sat16(input logic signed [32:0] v);
        logic signed [15:0] r;
        if (v > 33'sd32767) begin
            r = 16'sh7FFF;
        end else if (v < -33'sd32768) begin
            r = 16'sh8000;
        end else begin
            r = v[15:0];
        end
        return r;
    endfunction

    logic signed [15:0]    buffer [0:DELAY-1];
    logic signed [15:0]    rd_r;

    state_t                state_r;
    state_t                state_nxt_s;
    logic signed [15:0]    x_r;
    logic signed [31:0]    prod_r;
    logic [ADDR_WIDTH-1:0] ptr_r;
    logic [FILL_WIDTH-1:0] fill_r;
    logic signed [15:0]    dout_r;
    logic                  dout_valid_r;
    logic                  busy_r;
    logic                  overrun_r;

    logic signed [15:0]    old_s;
    logic signed [31:0]    old_ext_s;
    logic signed [31:0]    prod_full_s;
    logic signed [31:0]    prod_shift_s;
    logic signed [32:0]    diff_s;

    // Delay RAM: registered read in READ, write of the current sample in OUT.
    // Both use ptr_r, in different cycles, so there is never a collision.
    always_ff @(posedge clk) begin
        if (state_r == OUT) begin
            buffer[ptr_r] <= x_r;
        end
        if (state_r == READ) begin
            rd_r <= buffer[ptr_r];
        end
    end

    // Datapath: gate stale RAM contents until DELAY samples have been written,
    // then scale by g with a floor (arithmetic shift) and form x - g*old.
    always_comb begin
        old_s        = 16'sd0;
        if (fill_r == FILL_FULL) begin
            old_s = rd_r;
        end else begin
            old_s = 16'sd0;
        end
        old_ext_s    = 32'(old_s);
        prod_full_s  = old_ext_s * FB_EXT;
        prod_shift_s = prod_full_s >>> 15;
        diff_s       = 33'(x_r) - 33'(prod_r);
    end

    // FSM next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (din_valid) begin
                    state_nxt_s = READ;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            READ:    state_nxt_s = CALC;
            CALC:    state_nxt_s = OUT;
            OUT:     state_nxt_s = IDLE;
            default: state_nxt_s = IDLE;
        endcase
    end

    // State register, sample pipeline, pointer/fill bookkeeping and outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r      <= IDLE;
            x_r          <= 16'sd0;
            prod_r       <= 32'sd0;
            ptr_r        <= {ADDR_WIDTH{1'b0}};
            fill_r       <= {FILL_WIDTH{1'b0}};
            dout_r       <= 16'sd0;
            dout_valid_r <= 1'b0;
            busy_r       <= 1'b0;
            overrun_r    <= 1'b0;
        end else begin
            state_r      <= state_nxt_s;
            busy_r       <= (state_nxt_s != IDLE);
            dout_valid_r <= 1'b0;

            // A strobe while busy is dropped; only the sticky flag records it.
            if (din_valid && (state_r != IDLE)) begin
                overrun_r <= 1'b1;
            end

            case (state_r)
                IDLE: begin
                    if (din_valid) begin
                        x_r <= din;
                    end
                end
                READ: begin
                end
                CALC: begin
                    prod_r <= prod_shift_s;
                end
                OUT: begin
                    dout_r       <= sat16(diff_s);
                    dout_valid_r <= 1'b1;
                    if (ptr_r == LAST_ADDR) begin
                        ptr_r <= {ADDR_WIDTH{1'b0}};
                    end else begin
                        ptr_r <= ptr_r + ADDR_WIDTH'(1);
                    end
                    if (fill_r != FILL_FULL) begin
                        fill_r <= fill_r + FILL_WIDTH'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign dout       = dout_r;
    assign dout_valid = dout_valid_r;
    assign busy       = busy_r;
    assign overrun    = overrun_r;

endmodule

// File: tb/tb_inverse_comb_filter.sv
// -----------------------------------------------------------------------------
// tb_inverse_comb_filter
//
// Self-checking bench for inverse_comb_filter with DELAY = 4 and the default
// gain. A behavioural model keeps the list of accepted samples since reset and
// computes every expected output straight from y[n] = x[n] - floor(g*x[n-D])
// with saturation; a single compare process checks dout/dout_valid/busy/overrun
// on every falling edge. Directed scenarios also check literal values.
// -----------------------------------------------------------------------------
module tb_inverse_comb_filter;

    localparam int D  = 4;
    localparam int FB = 22937;

    logic               clk = 1'b0;
    logic               reset = 1'b0;
    logic signed [15:0] din = 16'sd0;
    logic               din_valid = 1'b0;
    logic signed [15:0] dout;
    logic               dout_valid;
    logic               busy;
    logic               overrun;

    inverse_comb_filter #(
        .DELAY    (D),
        .FEEDBACK (16'sd22937)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .din        (din),
        .din_valid  (din_valid),
        .dout       (dout),
        .dout_valid (dout_valid),
        .busy       (busy),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;

    typedef struct {
        int due;
        int val;
    } exp_t;

    exp_t q[$];        // expected outputs with the cycle they are due
    int   hist[$];     // accepted samples since reset
    int   outs[$];     // observed outputs, for literal checks
    bit   ov_exp   = 1'b0;
    bit   acc_seen = 1'b0;
    int   acc_cyc  = 0;
    int   last_dout = 0;

    task automatic check(input string name, input int act, input int req);
        tests++;
        if (act != req) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic int sat(input longint v);
        if (v > 32767) return 32767;
        if (v < -32768) return -32768;
        return int'(v);
    endfunction

    function automatic int floor_gain(input int v);
        return $rtoi($floor(real'(v) * real'(FB) / 32768.0));
    endfunction

    // Drive one strobe; the model decides whether the block can accept it.
    task automatic strobe(input int v);
        int n;
        int y;
        logic [15:0] r;
        @(negedge clk);
        din       = 16'(v);
        din_valid = 1'b1;
        @(posedge clk);
        #1;
        din_valid = 1'b0;
        r   = 16'($urandom);
        din = r;
        if (!acc_seen || (cyc - acc_cyc) >= 4) begin
            hist.push_back(v);
            n = hist.size() - 1;
            if (n < D) y = v;
            else       y = sat(longint'(v) - longint'(floor_gain(hist[n - D])));
            q.push_back('{cyc + 3, y});
            acc_seen = 1'b1;
            acc_cyc  = cyc;
        end else begin
            ov_exp = 1'b1;
        end
    endtask

    task automatic send(input int v);
        strobe(v);
        repeat (3) @(posedge clk);
    endtask

    task automatic model_clear();
        hist.delete();
        q.delete();
        outs.delete();
        ov_exp    = 1'b0;
        acc_seen  = 1'b0;
        last_dout = 0;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_clear();
        repeat (2) @(negedge clk);
        #2;
        reset = 1'b1;
    endtask

    task automatic lit(input string name, input int idx, input int val);
        if (idx < outs.size()) check(name, outs[idx], val);
        else                   check({name, "_count"}, outs.size(), idx + 1);
    endtask

    // Compare process: checks every cycle against the model.
    always @(negedge clk) begin
        if (!reset) begin
            check("rst_dout", int'(dout), 0);
            check("rst_dout_valid", int'(dout_valid), 0);
            check("rst_busy", int'(busy), 0);
            check("rst_overrun", int'(overrun), 0);
        end else begin
            check("busy", int'(busy), int'(acc_seen && ((cyc - acc_cyc) < 3)));
            check("overrun", int'(overrun), int'(ov_exp));
            if (dout_valid) begin
                if (q.size() == 0) begin
                    check("dout_valid_unexpected", 1, 0);
                end else begin
                    check("dout_time", cyc, q[0].due);
                    check("dout", int'(dout), q[0].val);
                    void'(q.pop_front());
                end
                last_dout = int'(dout);
                outs.push_back(int'(dout));
            end else begin
                if (q.size() > 0 && q[0].due <= cyc) begin
                    check("dout_valid_missing", 0, 1);
                    void'(q.pop_front());
                end
                check("dout_hold", int'(dout), last_dout);
            end
        end
    end

    initial begin
        int c[$];
        int s[$];
        int bad;
        int v;
        int gap;
        logic [15:0] r;

        // Reset then priming: first D outputs equal their inputs.
        do_reset();
        send(100); send(200); send(300); send(400);
        repeat (2) @(posedge clk);
        lit("prime0", 0, 100); lit("prime1", 1, 200);
        lit("prime2", 2, 300); lit("prime3", 3, 400);

        // Impulse response.
        do_reset();
        send(16384);
        repeat (6) send(0);
        repeat (2) @(posedge clk);
        lit("imp0", 0, 16384); lit("imp3", 3, 0);
        lit("imp4", 4, -11468); lit("imp5", 5, 0); lit("imp6", 6, 0);

        // Saturation at both rails.
        do_reset();
        send(-32768); send(0); send(0); send(0); send(32767);
        repeat (2) @(posedge clk);
        lit("sat_pos", 4, 32767);
        do_reset();
        send(32767); send(0); send(0); send(0); send(-32768);
        repeat (2) @(posedge clk);
        lit("sat_neg", 4, -32768);

        // Overrun: second strobe at E2 is dropped and never reaches the RAM.
        do_reset();
        strobe(1000);
        @(posedge clk);
        strobe(2000);
        @(posedge clk);
        check("ovr_sticky_now", int'(overrun), 1);
        repeat (4) send(0);
        repeat (2) @(posedge clk);
        check("ovr_count", outs.size(), 5);
        lit("ovr_first", 0, 1000);
        lit("ovr_echo", 4, -699);
        check("ovr_sticky_later", int'(overrun), 1);

        // Reset mid-sample: in-flight sample discarded, fill restarts.
        do_reset();
        send(1000); send(2000); send(3000); send(4000); send(5000);
        strobe(7000);
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_clear();
        repeat (3) @(negedge clk);
        #2;
        reset = 1'b1;
        send(11); send(22); send(33); send(44);
        repeat (2) @(posedge clk);
        check("rmid_count", outs.size(), 4);
        lit("rmid0", 0, 11); lit("rmid1", 1, 22);
        lit("rmid2", 2, 33); lit("rmid3", 3, 44);

        // Round trip: feedback comb in the bench, then the DUT undoes it.
        do_reset();
        for (int n = 0; n < 200; n++) begin
            int sv;
            int cv;
            sv = $rtoi(8000.0 * $sin(2.0 * 3.14159265358979 * 1000.0 * real'(n) / 48000.0));
            cv = sv + ((n >= D) ? floor_gain(c[n - D]) : 0);
            s.push_back(sv);
            c.push_back(cv);
            send(cv);
        end
        repeat (2) @(posedge clk);
        bad = 0;
        for (int n = 0; n < 200; n++) begin
            if (n >= outs.size()) bad++;
            else if (outs[n] - s[n] > 2 || s[n] - outs[n] > 2) bad++;
        end
        check("roundtrip_errors", bad, 0);

        // Randomised traffic with random gaps, including overruns.
        do_reset();
        for (int i = 0; i < 300; i++) begin
            r   = 16'($urandom);
            v   = int'($signed(r));
            gap = int'($urandom_range(0, 5));
            strobe(v);
            repeat (gap) @(posedge clk);
        end
        repeat (6) @(posedge clk);
        check("drain_empty", q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Watchdog so the run always ends.
    initial begin
        #5_000_000;
        fails++;
        $display("FAIL watchdog: got timeout, expected completion");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
